seq_multiplier: RTL and testbench
=================================

# seq_multiplier

Iterative shift-add multiplier producing the full 2n-bit product of two n-bit operands, one partial-product bit per cycle. Sits beside the ALU's ripple-carry adder stage in the execute unit and serves RV32M MUL/MULH/MULHSU/MULHU. The core decodes the operand signedness and picks the low or high half. Operates on magnitudes internally and applies a final two's-complement fix-up for signed results.

## Interface
- n, 32: operand width; must be ≥ 4.
- clk  in  1  system clock, rising edge.
- rst  in  1  synchronous, active-high reset.
- start  in  1  request; sampled only when busy=0.
- a  in  n  multiplicand.
- b  in  n  multiplier.
- a_signed  in  1  treat a as two's complement.
- b_signed  in  1  treat b as two's complement.
- busy  out  1  operation in progress.
- done  out  1  one-cycle pulse; result valid.
- result_lo  out  n  product bits [n-1:0].
- result_hi  out  n  product bits [2n-1:n].

## Operation
- States: IDLE, RUN, FIX, DONE.
- IDLE/DONE with start=1:
  - Latch |a| and |b|. Magnitude = negate if signed flag and MSB set; −2^(n−1) maps to 2^(n−1) as an unsigned n-bit value.
  - Latch neg = (a_signed&a[n-1]) ^ (b_signed&b[n-1]).
  - Clear the 2n-bit product register P; set the multiplier register to |b|; set the counter to n; go to RUN.
- RUN, each cycle:
  - If multiplier LSB = 1, compute sum = P[2n-1:n] + |a| with carry c; otherwise sum = P[2n-1:n] and c = 0.
  - P ← {c, sum, P[n-1:1]}. Shift the multiplier right by 1 and decrement the counter.
  - When the counter reaches 0 after this update, go to FIX.
- FIX: if neg, P ← −P (2n-bit two's complement); go to DONE.
- DONE: done=1 for this cycle only. Go to IDLE unless start=1 (back-to-back accept).
- result_lo/result_hi always drive P. They hold their value until the next accepted start clears P.
- start while busy=1 is ignored; operands are not re-sampled.
- Reset values: state IDLE, busy=0, done=0, result_lo=0, result_hi=0, counter=0.
- Reset mid-operation aborts immediately with no done pulse; the next cycle is IDLE.

## Timing
- Cycle 0: start=1 sampled at the closing edge.
- Cycles 1..n: RUN, busy=1.
- Cycle n+1: FIX, busy=1.
- Cycle n+2: DONE, done=1, busy=0, result valid.
- Latency: n+2 cycles from start to done. Throughput: one operation per n+2 cycles; a start in the DONE cycle begins RUN in the next cycle.
- Outputs are registered; no combinational path from inputs to outputs.

## Configuration
- SEQ_MUL_ZERO_SKIP_EN defined:
  - If |a|=0 or |b|=0 at accept, go straight from accept to DONE with P=0.
  - done asserts in cycle 1; busy stays 0 throughout.
- Undefined: zero operands take the full n+2 cycles and produce 0.

## Structure
- Package seq_mul_pkg holds:
  - the state enum (IDLE, RUN, FIX, DONE);
  - localparam CNT_W = $clog2(n+1).
- Sub-module seq_mul_step: combinational single iteration. Inputs P, |a|, multiplier LSB; output next P, including the n-bit add with carry into P[2n-1].

## Test plan
- n=8, unsigned, a=6, b=7 → done at cycle 10; {hi,lo}=0x002A.
- n=8, signed both, a=0xFD (−3), b=0x05 → {hi,lo}=0xFFF1.
- n=8, unsigned, a=b=0xFF → 0xFE01.
- n=8, signed a, unsigned b, a=0xFF (−1), b=0xFF → 0xFF01.
- n=8, signed both, a=b=0x80 → 0x4000.
- Control scenario:
  - start again in cycle 3 with different operands → ignored, original result.
  - rst in cycle 5 → busy=0 next cycle, no done, outputs 0.
  - start in the DONE cycle → second done exactly 10 cycles later.
  - With SEQ_MUL_ZERO_SKIP_EN, a=0, b=0x55 → done at cycle 1, result 0.

Source files
------------

// File: rtl/seq_mul_pkg.sv
// Shared types and sizing helpers for the sequential shift-add multiplier.
package seq_mul_pkg;

  // Controller states: accept, iterate, sign fix-up, completion pulse.
  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_FIX  = 2'd2,
    ST_DONE = 2'd3
  } state_e;

  // Operand width used when the top is not overridden.
  localparam int SEQ_MUL_N = 32;

  // Counter width able to hold the value n (iteration count).
  function automatic int cnt_width(input int n);
    return $clog2(n + 1);
  endfunction

  localparam int CNT_W = cnt_width(SEQ_MUL_N);

endpackage

// File: rtl/seq_multiplier_if.sv
// Request/result bundle of the sequential multiplier.
// master: the requesting core side; slave: the multiplier.
interface seq_multiplier_if #(
  parameter int N = 32
);
  logic         start;
  logic [N-1:0] a;
  logic [N-1:0] b;
  logic         a_signed;
  logic         b_signed;
  logic         busy;
  logic         done;
  logic [N-1:0] result_lo;
  logic [N-1:0] result_hi;

  modport master (
    output start, a, b, a_signed, b_signed,
    input  busy, done, result_lo, result_hi
  );

  modport slave (
    input  start, a, b, a_signed, b_signed,
    output busy, done, result_lo, result_hi
  );
endinterface

// File: rtl/seq_mul_step.sv
// One shift-add iteration: conditionally add |a| into the upper half of P,
// then shift the whole product right by one with the carry entering the MSB.
// P[0] is shifted out each step, so only P[2N-1:1] is taken as input.
module seq_mul_step
  import seq_mul_pkg::*;
#(
  parameter int N = 32
) (
  input  logic [2*N-1:1] i_p_upper,
  input  logic [N-1:0]   i_a_mag,
  input  logic           i_lsb,
  output logic [2*N-1:0] o_p_next
);

  logic [N:0] w_addend;
  logic [N:0] w_sum;

  // Select the addend and form the (n+1)-bit sum whose top bit is the carry.
  always_comb begin
    w_addend = {(N+1){1'b0}};
    if (i_lsb) begin
      w_addend = {1'b0, i_a_mag};
    end else begin
      w_addend = {(N+1){1'b0}};
    end
    w_sum    = {1'b0, i_p_upper[2*N-1:N]} + w_addend;
    o_p_next = {w_sum, i_p_upper[N-1:1]};
  end

endmodule

// File: rtl/seq_multiplier.sv
// Iterative shift-add multiplier: full 2N-bit product, one multiplier bit per
// cycle, magnitudes internally with a final two's-complement fix-up.
// Optional build macro: SEQ_MUL_ZERO_SKIP_EN (zero operand completes at once).
module seq_multiplier
  import seq_mul_pkg::*;
#(
  parameter int N = SEQ_MUL_N
) (
  input  logic             i_clk,
  input  logic             i_rst,
  seq_multiplier_if.slave  io_bus
);

  localparam int            W_CNT   = cnt_width(N);
  localparam logic [N-1:0]  ONE_N   = {{(N-1){1'b0}}, 1'b1};
  localparam logic [N-1:0]  ZERO_N  = {N{1'b0}};
  localparam logic [2*N-1:0] ONE_2N = {{(2*N-1){1'b0}}, 1'b1};
  localparam logic [2*N-1:0] ZERO_2N = {(2*N){1'b0}};
  localparam logic [W_CNT-1:0] ONE_CNT = {{(W_CNT-1){1'b0}}, 1'b1};

  state_e           r_state;
  logic [2*N-1:0]   r_p;
  logic [N-1:0]     r_a_mag;
  logic [N-1:0]     r_b_mul;
  logic [W_CNT-1:0] r_cnt;
  logic             r_neg;
  logic             r_busy;
  logic             r_done;

  state_e           w_state_next;
  logic [2*N-1:0]   w_p_next;
  logic [N-1:0]     w_a_next;
  logic [N-1:0]     w_b_next;
  logic [W_CNT-1:0] w_cnt_next;
  logic [W_CNT-1:0] w_cnt_dec;
  logic             w_neg_next;
  logic [N-1:0]     w_a_mag;
  logic [N-1:0]     w_b_mag;
  logic [2*N-1:0]   w_step_p;

  // Operand magnitudes; -2^(N-1) negates to itself, read as unsigned 2^(N-1).
  always_comb begin
    w_a_mag = io_bus.a;
    w_b_mag = io_bus.b;
    if (io_bus.a_signed && io_bus.a[N-1]) begin
      w_a_mag = ~io_bus.a + ONE_N;
    end else begin
      w_a_mag = io_bus.a;
    end
    if (io_bus.b_signed && io_bus.b[N-1]) begin
      w_b_mag = ~io_bus.b + ONE_N;
    end else begin
      w_b_mag = io_bus.b;
    end
  end

  seq_mul_step #(.N(N)) u_step (
    .i_p_upper (r_p[2*N-1:1]),
    .i_a_mag   (r_a_mag),
    .i_lsb     (r_b_mul[0]),
    .o_p_next  (w_step_p)
  );

  assign w_cnt_dec = r_cnt - ONE_CNT;

  // Next-state and datapath update for the IDLE/RUN/FIX/DONE controller.
  always_comb begin
    w_state_next = r_state;
    w_p_next     = r_p;
    w_a_next     = r_a_mag;
    w_b_next     = r_b_mul;
    w_cnt_next   = r_cnt;
    w_neg_next   = r_neg;
    case (r_state)
      ST_IDLE, ST_DONE: begin
        if (io_bus.start) begin
          w_a_next   = w_a_mag;
          w_b_next   = w_b_mag;
          w_neg_next = (io_bus.a_signed & io_bus.a[N-1]) ^ (io_bus.b_signed & io_bus.b[N-1]);
          w_p_next   = ZERO_2N;
          w_cnt_next = W_CNT'(N);
`ifdef SEQ_MUL_ZERO_SKIP_EN
          if ((w_a_mag == ZERO_N) || (w_b_mag == ZERO_N)) begin
            w_state_next = ST_DONE;
          end else begin
            w_state_next = ST_RUN;
          end
`else
          w_state_next = ST_RUN;
`endif
        end else begin
          w_state_next = ST_IDLE;
        end
      end
      ST_RUN: begin
        w_p_next   = w_step_p;
        w_b_next   = r_b_mul >> 1;
        w_cnt_next = w_cnt_dec;
        if (w_cnt_dec == {W_CNT{1'b0}}) begin
          w_state_next = ST_FIX;
        end else begin
          w_state_next = ST_RUN;
        end
      end
      ST_FIX: begin
        if (r_neg) begin
          w_p_next = ~r_p + ONE_2N;
        end else begin
          w_p_next = r_p;
        end
        w_state_next = ST_DONE;
      end
      default: begin
        w_state_next = ST_IDLE;
      end
    endcase
  end

  // State, datapath and registered status flags; synchronous reset aborts any operation.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_state <= ST_IDLE;
      r_p     <= ZERO_2N;
      r_a_mag <= ZERO_N;
      r_b_mul <= ZERO_N;
      r_cnt   <= {W_CNT{1'b0}};
      r_neg   <= 1'b0;
      r_busy  <= 1'b0;
      r_done  <= 1'b0;
    end else begin
      r_state <= w_state_next;
      r_p     <= w_p_next;
      r_a_mag <= w_a_next;
      r_b_mul <= w_b_next;
      r_cnt   <= w_cnt_next;
      r_neg   <= w_neg_next;
      r_busy  <= (w_state_next == ST_RUN) || (w_state_next == ST_FIX);
      r_done  <= (w_state_next == ST_DONE);
    end
  end

  assign io_bus.busy      = r_busy;
  assign io_bus.done      = r_done;
  assign io_bus.result_lo = r_p[N-1:0];
  assign io_bus.result_hi = r_p[2*N-1:N];

endmodule

// File: tb/tb_seq_multiplier.sv
// Self-checking bench for seq_multiplier at N=8: directed products, random
// signed/unsigned products against an arithmetic reference, and control cases.
module tb_seq_multiplier;

  localparam int N   = 8;
  localparam int LAT = N + 2;
`ifdef SEQ_MUL_ZERO_SKIP_EN
  localparam int ZERO_LAT = 1;
`else
  localparam int ZERO_LAT = LAT;
`endif

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   errors = 0;
  int   checks = 0;

  always #5 clk = ~clk;

  seq_multiplier_if #(.N(N)) bus ();

  seq_multiplier #(.N(N)) dut (
    .i_clk  (clk),
    .i_rst  (rst),
    .io_bus (bus.slave)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  // Reference: the mathematical product of the operands as interpreted.
  function automatic logic [2*N-1:0] ref_mul(input logic [N-1:0] a, input logic [N-1:0] b,
                                             input logic as, input logic bs);
    longint sa, sb, prod;
    sa   = as ? longint'($signed(a)) : longint'(a);
    sb   = bs ? longint'($signed(b)) : longint'(b);
    prod = sa * sb;
    return prod[2*N-1:0];
  endfunction

  task automatic drive(input logic [N-1:0] a, input logic [N-1:0] b,
                       input logic as, input logic bs);
    bus.start    = 1'b1;
    bus.a        = a;
    bus.b        = b;
    bus.a_signed = as;
    bus.b_signed = bs;
  endtask

  // Called at the negedge of the accept cycle; returns at the negedge of the done cycle.
  task automatic wait_done(input string tag, input int exp_lat, input logic [2*N-1:0] exp_p,
                           input int inj_cyc, input logic [N-1:0] inj_a, input logic [N-1:0] inj_b);
    int cyc = 0;
    bit got = 1'b0;
    int busy_bad = 0;
    while (!got && cyc < 4 * LAT) begin
      @(negedge clk);
      cyc++;
      if (cyc == 1) bus.start = 1'b0;
      if (cyc == inj_cyc) begin
        bus.start = 1'b1;
        bus.a     = inj_a;
        bus.b     = inj_b;
      end
      if (cyc == inj_cyc + 1) bus.start = 1'b0;
      if (bus.done === 1'b1) got = 1'b1;
      else if (bus.busy !== 1'b1) busy_bad++;
    end
    chk({tag, " latency"}, cyc, exp_lat);
    chk({tag, " result"}, {bus.result_hi, bus.result_lo}, exp_p);
    chk({tag, " busy at done"}, bus.busy, 1'b0);
    chk({tag, " busy during op"}, busy_bad, 0);
  endtask

  task automatic run_op(input string tag, input logic [N-1:0] a, input logic [N-1:0] b,
                        input logic as, input logic bs, input int exp_lat);
    logic [2*N-1:0] exp_p;
    exp_p = ref_mul(a, b, as, bs);
    drive(a, b, as, bs);
    wait_done(tag, exp_lat, exp_p, 0, '0, '0);
    @(negedge clk);
    chk({tag, " done single cycle"}, bus.done, 1'b0);
    chk({tag, " result held"}, {bus.result_hi, bus.result_lo}, exp_p);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    logic [N-1:0] ra, rb;
    logic ras, rbs;
    int dones;

    bus.start = 1'b0; bus.a = '0; bus.b = '0; bus.a_signed = 1'b0; bus.b_signed = 1'b0;
    rst = 1'b1;
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;
    chk("reset busy", bus.busy, 1'b0);
    chk("reset done", bus.done, 1'b0);
    chk("reset lo", bus.result_lo, 8'h00);
    chk("reset hi", bus.result_hi, 8'h00);

    // Directed products.
    run_op("u 6x7", 8'd6, 8'd7, 1'b0, 1'b0, LAT);
    chk("u 6x7 const", {bus.result_hi, bus.result_lo}, 16'h002A);
    run_op("s -3x5", 8'hFD, 8'h05, 1'b1, 1'b1, LAT);
    chk("s -3x5 const", {bus.result_hi, bus.result_lo}, 16'hFFF1);
    run_op("u FFxFF", 8'hFF, 8'hFF, 1'b0, 1'b0, LAT);
    chk("u FFxFF const", {bus.result_hi, bus.result_lo}, 16'hFE01);
    run_op("su -1xFF", 8'hFF, 8'hFF, 1'b1, 1'b0, LAT);
    chk("su -1xFF const", {bus.result_hi, bus.result_lo}, 16'hFF01);
    run_op("s 80x80", 8'h80, 8'h80, 1'b1, 1'b1, LAT);
    chk("s 80x80 const", {bus.result_hi, bus.result_lo}, 16'h4000);

    // Random operands and signedness.
    for (int i = 0; i < 20; i++) begin
      ra  = N'($urandom_range(1, 255));
      rb  = N'($urandom_range(1, 255));
      ras = 1'($urandom_range(0, 1));
      rbs = 1'($urandom_range(0, 1));
      run_op("random", ra, rb, ras, rbs, LAT);
    end

    // Start while busy is ignored.
    drive(8'd6, 8'd7, 1'b0, 1'b0);
    wait_done("ignore start", LAT, 16'h002A, 3, 8'hFF, 8'hFF);
    @(negedge clk);

    // Reset mid-operation.
    drive(8'd9, 8'd11, 1'b0, 1'b0);
    for (int i = 1; i <= 5; i++) begin
      @(negedge clk);
      if (i == 1) bus.start = 1'b0;
      if (i == 5) rst = 1'b1;
    end
    @(negedge clk);
    rst = 1'b0;
    chk("abort busy", bus.busy, 1'b0);
    chk("abort done", bus.done, 1'b0);
    chk("abort lo", bus.result_lo, 8'h00);
    chk("abort hi", bus.result_hi, 8'h00);
    dones = 0;
    for (int i = 0; i < 3 * LAT; i++) begin
      @(negedge clk);
      if (bus.done === 1'b1) dones++;
    end
    chk("abort no done", dones, 0);

    // Back-to-back accept in the DONE cycle.
    drive(8'd13, 8'd17, 1'b0, 1'b0);
    wait_done("b2b first", LAT, ref_mul(8'd13, 8'd17, 1'b0, 1'b0), 0, '0, '0);
    drive(8'hF0, 8'h0B, 1'b1, 1'b0);
    wait_done("b2b second", LAT, ref_mul(8'hF0, 8'h0B, 1'b1, 1'b0), 0, '0, '0);
    @(negedge clk);

    // Zero operand.
    run_op("zero a", 8'h00, 8'h55, 1'b0, 1'b0, ZERO_LAT);
    chk("zero a const", {bus.result_hi, bus.result_lo}, 16'h0000);
    run_op("zero b", 8'h93, 8'h00, 1'b1, 1'b1, ZERO_LAT);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
